sram_sdp_be: RTL and testbench
==============================

// Module: sram_sdp_be
// PURPOSE
//   Simple-dual-port SRAM with one write port, one read port and byte enables. Successor
//   to the single-port SRAM: writes and reads can happen in the same cycle.
//   Adds a hardware clear sweep (FSM), write-first bypass for same-address collisions,
//   and a registered read with a valid strobe. Used as the node/table store in BDD datapaths.
// PARAMETERS
//   ADDR_WIDTH  5   address bits on both ports
//   DATA_WIDTH  32  word width; must be a multiple of 8
//   DEPTH       32  number of words, DEPTH <= 2**ADDR_WIDTH
//   (localparam NUM_BE = DATA_WIDTH/8)
// PORTS
//   i_clk       in   1           clock, all logic on posedge
//   i_rst_n     in   1           asynchronous active-low reset
//   i_clear     in   1           pulse: restart clear sweep (zero all words)
//   o_ready     out  1           1 = RUN state, requests accepted
//   i_wr_en     in   1           write request
//   i_wr_addr   in   ADDR_WIDTH  write address
//   i_wr_data   in   DATA_WIDTH  write data
//   i_wr_be     in   NUM_BE      byte enables, bit k -> data[8k+7:8k]
//   i_par_inj   in   1           test: invert stored parity of enabled lanes (parity build only)
//   i_rd_en     in   1           read request
//   i_rd_addr   in   ADDR_WIDTH  read address
//   o_rd_data   out  DATA_WIDTH  registered read data
//   o_rd_valid  out  1           1-cycle strobe, o_rd_data valid
//   o_par_err   out  1           parity error, qualified by o_rd_valid
// BEHAVIOUR
//   Reset (async, i_rst_n=0): FSM->INIT, clr_cnt=0, o_rd_data=0, o_rd_valid=0,
//     o_ready=0, o_par_err=0. Memory array is not reset; the INIT sweep clears it.
//   FSM INIT: each cycle write 0 (parity 0) to mem[clr_cnt], clr_cnt++; after writing
//     DEPTH-1 -> RUN. Sweep lasts exactly DEPTH cycles after reset release; o_ready=0.
//     i_wr_en/i_rd_en ignored in INIT (no write, no o_rd_valid).
//     i_clear in INIT restarts the sweep at clr_cnt=0.
//   FSM RUN: o_ready=1. i_clear=1 -> INIT next cycle with clr_cnt=0. Any read/write
//     presented in that same cycle still executes, and the read returns pre-clear data.
//   Write (RUN, i_wr_en): for each k with i_wr_be[k]=1, mem[i_wr_addr] lane k <= data
//     lane k; other lanes unchanged. be=0 is a no-op. Addr >= DEPTH: write dropped.
//   Read (RUN, i_rd_en): latency 1; next cycle o_rd_valid=1, o_rd_data=mem[i_rd_addr].
//     Without i_rd_en, o_rd_valid=0 and o_rd_data holds its last value.
//     Addr >= DEPTH: returns 0 with o_rd_valid=1, o_par_err=0.
//   Collision (read and write, same address, same cycle): write-first. Read data =
//     new lanes where i_wr_be set, old lanes elsewhere. Write to a different address:
//     no interaction.
//   Back-to-back reads every cycle give one o_rd_valid per cycle, in order.
// CONFIGURATION
//   SRAM_PARITY_EN defined: one extra even-parity bit per byte lane is stored. On write,
//     par[k] = ^data lane k, XOR i_par_inj. On read, o_par_err=1 together with
//     o_rd_valid if any lane's recomputed parity differs from the stored bit. The
//     collision bypass uses computed (not injected) parity for written lanes.
//   Undefined: no parity storage, i_par_inj ignored, o_par_err tied 0.
// TESTING
//   1 Reset release, DEPTH=32 -> o_ready=0 for 32 cycles, then 1; read any addr -> 0.
//   2 Write 0xDEADBEEF to addr 3 with be=4'b1111, then write 0x00AA0000 with be=4'b0100;
//     read 3 -> 0xDEAABEEF, valid 1 cycle later.
//   3 Same cycle: write addr 5 = 0x12345678 with be=4'b0011 over old 0xFFFFFFFF, and
//     read addr 5 -> 0xFFFF5678.
//   4 Fill addrs 0..31, pulse i_clear -> o_ready low for 32 cycles; then read addr 31 -> 0.
//     A read issued with i_clear returns the old data.
//   5 Read addr 40 (ADDR_WIDTH=6) -> 0, valid=1. Write to addr 40 then read addr 8 ->
//     unchanged.
//   6 SRAM_PARITY_EN: write addr 2 with i_par_inj=1 -> read 2 gives o_par_err=1;
//     rewrite with i_par_inj=0 -> o_par_err=0.

Source files
------------

// File: rtl/sram_sdp_be_if.sv
// Request/response bundle for sram_sdp_be: one write port, one read port, clear pulse.
// master = requester side, slave = memory side.
interface sram_sdp_be_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   localparam int NUM_BE = DATA_WIDTH / 8;

   logic                  i_clear;
   logic                  o_ready;
   logic                  i_wr_en;
   logic [ADDR_WIDTH-1:0] i_wr_addr;
   logic [DATA_WIDTH-1:0] i_wr_data;
   logic [NUM_BE-1:0]     i_wr_be;
   logic                  i_par_inj;
   logic                  i_rd_en;
   logic [ADDR_WIDTH-1:0] i_rd_addr;
   logic [DATA_WIDTH-1:0] o_rd_data;
   logic                  o_rd_valid;
   logic                  o_par_err;

   modport master (
      output i_clear, i_wr_en, i_wr_addr, i_wr_data, i_wr_be, i_par_inj, i_rd_en, i_rd_addr,
      input  o_ready, o_rd_data, o_rd_valid, o_par_err
   );

   modport slave (
      input  i_clear, i_wr_en, i_wr_addr, i_wr_data, i_wr_be, i_par_inj, i_rd_en, i_rd_addr,
      output o_ready, o_rd_data, o_rd_valid, o_par_err
   );
endinterface

// File: rtl/sram_sdp_be.sv
// Simple-dual-port SRAM with byte enables, write-first collision bypass and a clear sweep.
// Optional per-byte even parity when SRAM_PARITY_EN is defined.
module sram_sdp_be #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   sram_sdp_be_if.slave   bus
);
   localparam int NUM_BE = DATA_WIDTH / 8;
   localparam int CNT_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   clr_cnt, clr_cnt_nxt;
   logic               run;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic               wr_in, rd_in, wr_ok, rd_ok, hit;
   logic [CNT_W-1:0]   wr_idx, rd_idx;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] rd_data_q;
   logic               rd_valid_q;

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= ST_INIT;
         clr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      run         = 1'b0;
      case (state)
         ST_INIT: begin
            if (bus.i_clear)
               clr_cnt_nxt = '0;
            else if (clr_cnt == CNT_W'(DEPTH - 1)) begin
               state_nxt   = ST_RUN;
               clr_cnt_nxt = '0;
            end else
               clr_cnt_nxt = clr_cnt + 1'b1;
         end
         ST_RUN: begin
            run = 1'b1;
            if (bus.i_clear) begin
               state_nxt   = ST_INIT;
               clr_cnt_nxt = '0;
            end
         end
      endcase
   end

   assign bus.o_ready = run;

   // ---------------- address decode ----------------
   assign wr_in  = {1'b0, bus.i_wr_addr} < (ADDR_WIDTH + 1)'(DEPTH);
   assign rd_in  = {1'b0, bus.i_rd_addr} < (ADDR_WIDTH + 1)'(DEPTH);
   assign wr_idx = bus.i_wr_addr[CNT_W-1:0];
   assign rd_idx = bus.i_rd_addr[CNT_W-1:0];
   assign wr_ok  = run && bus.i_wr_en && wr_in;
   assign rd_ok  = run && bus.i_rd_en;
   assign hit    = wr_ok && (bus.i_wr_addr == bus.i_rd_addr);

   // Array has no reset; INIT sweeps one word per cycle instead.
   always_ff @(posedge i_clk) begin
      if (!run)
         mem[clr_cnt] <= '0;
      else if (wr_ok)
         for (int k = 0; k < NUM_BE; k++)
            if (bus.i_wr_be[k]) mem[wr_idx][8*k +: 8] <= bus.i_wr_data[8*k +: 8];
   end

   // Write-first merge: freshly written lanes override the stored word.
   always_comb begin
      rd_word = mem[rd_idx];
      for (int k = 0; k < NUM_BE; k++)
         if (hit && bus.i_wr_be[k]) rd_word[8*k +: 8] = bus.i_wr_data[8*k +: 8];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_ok;
         if (rd_ok) rd_data_q <= rd_in ? rd_word : '0;
      end
   end

   assign bus.o_rd_data  = rd_data_q;
   assign bus.o_rd_valid = rd_valid_q;

`ifdef SRAM_PARITY_EN
   logic [NUM_BE-1:0] par_mem [DEPTH];
   logic [NUM_BE-1:0] wr_par, rd_par, rd_calc;
   logic              par_err_q;

   always_comb begin
      for (int k = 0; k < NUM_BE; k++)
         wr_par[k] = (^bus.i_wr_data[8*k +: 8]) ^ bus.i_par_inj;
   end

   always_ff @(posedge i_clk) begin
      if (!run)
         par_mem[clr_cnt] <= '0;
      else if (wr_ok)
         for (int k = 0; k < NUM_BE; k++)
            if (bus.i_wr_be[k]) par_mem[wr_idx][k] <= wr_par[k];
   end

   // Bypassed lanes carry clean parity so injection only shows up on a later read.
   always_comb begin
      rd_par = par_mem[rd_idx];
      for (int k = 0; k < NUM_BE; k++) begin
         rd_calc[k] = ^rd_word[8*k +: 8];
         if (hit && bus.i_wr_be[k]) rd_par[k] = rd_calc[k];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) par_err_q <= 1'b0;
      else          par_err_q <= rd_ok && rd_in && |(rd_calc ^ rd_par);
   end

   assign bus.o_par_err = par_err_q;
`else
   logic unused_par;
   assign unused_par    = bus.i_par_inj;
   assign bus.o_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_sdp_be.sv
// Directed bench for sram_sdp_be with a word-level reference model checked every cycle.
module tb_sram_sdp_be;
   localparam int AW = 6, DW = 32, DEPTH = 32, NB = 4;
`ifdef SRAM_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic i_clk = 1'b0;
   logic i_rst_n = 1'b0;
   always #5 i_clk = ~i_clk;

   sram_sdp_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   sram_sdp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) u_dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_mem [DEPTH];
   logic [3:0]  m_bad [DEPTH];   // lanes whose stored parity was injected
   bit          m_ready = 1'b0;
   int          m_left  = DEPTH;
   logic        e_valid = 1'b0;
   logic [31:0] e_data  = '0;
   logic        e_perr  = 1'b0;

   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         m_ready = 1'b0; m_left = DEPTH;
         e_valid = 1'b0; e_data = '0; e_perr = 1'b0;
      end else begin
         int ra, wa;
         logic [31:0] w;
         logic [3:0]  bad;
         ra = int'(bus.i_rd_addr);
         wa = int'(bus.i_wr_addr);
         e_valid = 1'b0;
         e_perr  = 1'b0;
         if (m_ready) begin
            if (bus.i_rd_en) begin
               e_valid = 1'b1;
               if (ra < DEPTH) begin
                  w = m_mem[ra]; bad = m_bad[ra];
                  if (bus.i_wr_en && wa == ra)
                     for (int k = 0; k < NB; k++)
                        if (bus.i_wr_be[k]) begin w[8*k +: 8] = bus.i_wr_data[8*k +: 8]; bad[k] = 1'b0; end
                  e_data = w;
                  e_perr = PAR && (bad != 4'b0);
               end else
                  e_data = '0;
            end
            if (bus.i_wr_en && wa < DEPTH)
               for (int k = 0; k < NB; k++)
                  if (bus.i_wr_be[k]) begin
                     m_mem[wa][8*k +: 8] = bus.i_wr_data[8*k +: 8];
                     m_bad[wa][k] = bus.i_par_inj;
                  end
            if (bus.i_clear) begin m_ready = 1'b0; m_left = DEPTH; end
         end else begin
            if (bus.i_clear) m_left = DEPTH;
            else             m_left--;
            if (m_left == 0) begin
               m_ready = 1'b1;
               for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_bad[i] = '0; end
            end
         end
      end
   end

   always @(negedge i_clk) begin
      if (i_rst_n) begin
         chk("mdl_ready", 32'(bus.o_ready), 32'(m_ready));
         chk("mdl_valid", 32'(bus.o_rd_valid), 32'(e_valid));
         chk("mdl_data", bus.o_rd_data, e_data);
         if (e_valid) chk("mdl_perr", 32'(bus.o_par_err), 32'(e_perr));
      end
   end

   // ---------------- stimulus helpers (called at negedge) ----------------
   task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be, input logic inj);
      bus.i_wr_en = 1'b1; bus.i_wr_addr = AW'(a); bus.i_wr_data = d;
      bus.i_wr_be = be; bus.i_par_inj = inj;
      @(negedge i_clk);
      bus.i_wr_en = 1'b0; bus.i_par_inj = 1'b0;
   endtask

   task automatic rd(input int a, output logic [31:0] d, output logic v, output logic pe);
      bus.i_rd_en = 1'b1; bus.i_rd_addr = AW'(a);
      @(negedge i_clk);
      d = bus.o_rd_data; v = bus.o_rd_valid; pe = bus.o_par_err;
      bus.i_rd_en = 1'b0;
   endtask

   task automatic wait_ready(input string name, input int exp_cycles);
      int n;
      n = 0;
      while (!bus.o_ready && n < 100) begin
         @(negedge i_clk);
         n++;
      end
      chk(name, 32'(n), 32'(exp_cycles));
   endtask

   logic [31:0] d;
   logic        v, pe;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.i_clear = 1'b0; bus.i_wr_en = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
      bus.i_wr_be = '0; bus.i_par_inj = 1'b0; bus.i_rd_en = 1'b0; bus.i_rd_addr = '0;

      // 1: reset values, sweep length, cleared contents
      repeat (3) @(negedge i_clk);
      chk("rst_ready", 32'(bus.o_ready), 32'd0);
      chk("rst_valid", 32'(bus.o_rd_valid), 32'd0);
      chk("rst_data", bus.o_rd_data, 32'd0);
      chk("rst_perr", 32'(bus.o_par_err), 32'd0);
      #2 i_rst_n = 1'b1;
      @(negedge i_clk);
      wait_ready("init_len", 31);   // first negedge already consumed one sweep cycle
      rd(7, d, v, pe);
      chk("init_rd7", d, 32'h0);
      chk("init_rd7_v", 32'(v), 32'd1);

      // 2: byte-enable merge, latency, hold
      wr(3, 32'hDEADBEEF, 4'b1111, 1'b0);
      wr(3, 32'h00AA0000, 4'b0100, 1'b0);
      rd(3, d, v, pe);
      chk("be_merge", d, 32'hDEAABEEF);
      chk("be_merge_v", 32'(v), 32'd1);
      @(negedge i_clk);
      chk("hold_v", 32'(bus.o_rd_valid), 32'd0);
      chk("hold_data", bus.o_rd_data, 32'hDEAABEEF);

      // 3: same-address collision (write-first), be=0 no-op, different address
      wr(5, 32'hFFFFFFFF, 4'b1111, 1'b0);
      bus.i_wr_en = 1'b1; bus.i_wr_addr = 6'd5; bus.i_wr_data = 32'h12345678; bus.i_wr_be = 4'b0011;
      rd(5, d, v, pe);
      bus.i_wr_en = 1'b0;
      chk("coll", d, 32'hFFFF5678);
      wr(5, 32'h0, 4'b0000, 1'b0);
      rd(5, d, v, pe);
      chk("be0_noop", d, 32'hFFFF5678);
      bus.i_wr_en = 1'b1; bus.i_wr_addr = 6'd6; bus.i_wr_data = 32'h0BADF00D; bus.i_wr_be = 4'b1111;
      rd(5, d, v, pe);
      bus.i_wr_en = 1'b0;
      chk("coll_diff", d, 32'hFFFF5678);

      // back-to-back reads
      bus.i_rd_en = 1'b1;
      bus.i_rd_addr = 6'd3; @(negedge i_clk);
      chk("b2b_0", bus.o_rd_data, 32'hDEAABEEF);
      bus.i_rd_addr = 6'd5; @(negedge i_clk);
      chk("b2b_1", bus.o_rd_data, 32'hFFFF5678);
      bus.i_rd_addr = 6'd6; @(negedge i_clk);
      chk("b2b_2", bus.o_rd_data, 32'h0BADF00D);
      chk("b2b_v", 32'(bus.o_rd_valid), 32'd1);
      bus.i_rd_en = 1'b0;

      // 5: out-of-range address
      rd(40, d, v, pe);
      chk("oor_rd", d, 32'h0);
      chk("oor_rd_v", 32'(v), 32'd1);
      chk("oor_perr", 32'(pe), 32'd0);
      wr(8, 32'h11223344, 4'b1111, 1'b0);
      wr(40, 32'hCAFEF00D, 4'b1111, 1'b0);
      rd(8, d, v, pe);
      chk("oor_wr_drop", d, 32'h11223344);

      // 6: parity injection
      wr(2, 32'h01020304, 4'b1111, 1'b1);
      rd(2, d, v, pe);
      chk("par_inj", 32'(pe), 32'(PAR));
      wr(2, 32'h01020304, 4'b1111, 1'b0);
      rd(2, d, v, pe);
      chk("par_clean", 32'(pe), 32'd0);
      bus.i_wr_en = 1'b1; bus.i_wr_addr = 6'd2; bus.i_wr_data = 32'h000000FF;
      bus.i_wr_be = 4'b0001; bus.i_par_inj = 1'b1;
      rd(2, d, v, pe);
      bus.i_wr_en = 1'b0; bus.i_par_inj = 1'b0;
      chk("par_bypass", 32'(pe), 32'd0);
      chk("par_bypass_d", d, 32'h010203FF);
      rd(2, d, v, pe);
      chk("par_stored", 32'(pe), 32'(PAR));

      // 4: fill, clear with concurrent read, restart sweep from INIT
      for (int i = 0; i < DEPTH; i++) wr(i, (32'(i) * 32'h01010101) ^ 32'hA5000000, 4'b1111, 1'b0);
      bus.i_clear = 1'b1;
      rd(31, d, v, pe);
      bus.i_clear = 1'b0;
      chk("clr_old_data", d, 32'hBA1F1F1F);
      chk("clr_ready", 32'(bus.o_ready), 32'd0);
      repeat (5) @(negedge i_clk);
      wr(1, 32'hFFFFFFFF, 4'b1111, 1'b0);
      rd(1, d, v, pe);
      chk("init_rd_ign", 32'(v), 32'd0);
      bus.i_clear = 1'b1;
      @(negedge i_clk);
      bus.i_clear = 1'b0;
      wait_ready("restart_len", 32);
      rd(31, d, v, pe);
      chk("clr_rd31", d, 32'h0);
      rd(1, d, v, pe);
      chk("clr_rd1", d, 32'h0);

      repeat (2) @(negedge i_clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
